// File: rtl/rdma_sq_credit_ctrl_pkg.sv
// Shared RDMA request/ACK types and geometry for the SQ credit controller.
// Stands in for the lynxTypes definitions used across the network stack.
package rdma_sq_credit_ctrl_pkg;

  localparam int unsigned DEF_N_REGIONS  = 4;
  localparam int unsigned N_REGIONS_BITS = 2;
  localparam int unsigned PID_BITS       = 6;
  localparam int unsigned QPN_BITS       = 24;
  localparam int unsigned MSG_BITS       = 64;
  localparam int unsigned MSN_BITS       = 24;

  typedef struct packed {
    logic [4:0]          opcode;
    logic [QPN_BITS-1:0] qpn;
    logic                host;
    logic                mode;
    logic [MSG_BITS-1:0] msg;
  } req_t;

  typedef struct packed {
    logic                      is_nak;
    logic [PID_BITS-1:0]       pid;
    logic [N_REGIONS_BITS-1:0] vfid;
    logic [7:0]                syndrome;
    logic [MSN_BITS-1:0]       msn;
  } ack_t;

  localparam int unsigned RDMA_REQ_BITS = $bits(req_t);
  localparam int unsigned RDMA_ACK_BITS = $bits(ack_t);

  // The region is encoded in the qpn bits directly above the process id.
  function automatic logic [N_REGIONS_BITS-1:0] req_vfid(input req_t r);
    return r.qpn[PID_BITS +: N_REGIONS_BITS];
  endfunction

endpackage

// File: rtl/rdma_sq_credit_ctrl_if.sv
// Valid/ready stream bundles for SQ requests and RoCE ACKs.
interface rdma_req_if;
  import rdma_sq_credit_ctrl_pkg::*;

  logic valid;
  logic ready;
  req_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface rdma_ack_if;
  import rdma_sq_credit_ctrl_pkg::*;

  logic valid;
  logic ready;
  ack_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rdma_sq_credit_ctrl_cnt.sv
// Per-region outstanding-request counter: saturating up/down, simultaneous
// inc/dec cancels, underflow flags a positive ACK arriving with nothing charged.
module rdma_credit_cnt #(
  parameter int unsigned MAX   = 32,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (cnt_q != CNT_W'(MAX)) cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_d     = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/rdma_sq_credit_ctrl.sv
// Per-region credit gate in front of the RoCE SQ: one-entry request and ACK
// register slices, one outstanding counter per region, NAK count, sticky error.
module rdma_sq_credit_ctrl
  import rdma_sq_credit_ctrl_pkg::*;
#(
  parameter int unsigned N_OUTSTANDING = 32,
  parameter int unsigned N_REGIONS     = DEF_N_REGIONS
) (
  input  logic                 nclk,
  input  logic                 nreset,
  rdma_req_if.slave            s_sq,
  rdma_req_if.master           m_sq,
  rdma_ack_if.slave            s_ack,
  rdma_ack_if.master           m_ack,
  output logic [N_REGIONS-1:0] credit_stall,
  output logic [31:0]          nak_count,
  output logic                 credit_err
);

  localparam int unsigned CNT_W = $clog2(N_OUTSTANDING + 1);

  logic [CNT_W-1:0]          cnt [N_REGIONS];
  logic [N_REGIONS-1:0]      inc;
  logic [N_REGIONS-1:0]      dec;
  logic [N_REGIONS-1:0]      full;
  logic [N_REGIONS-1:0]      underflow;

  logic [N_REGIONS_BITS-1:0] sq_vfid;
  logic [N_REGIONS_BITS-1:0] ack_vfid;
  logic                      sq_has_credit;
  logic                      sq_accept;
  logic                      ack_accept;
  logic                      ack_pos;

  logic                      sq_valid_q;
  req_t                      sq_data_q;
  logic                      ack_valid_q;
  ack_t                      ack_data_q;
  logic [31:0]               nak_cnt_q;
  logic                      credit_err_q;

  assign sq_vfid  = req_vfid(s_sq.data);
  assign ack_vfid = s_ack.data.vfid;

  // Credit lookup for the head request's region; an unmapped vfid has no credit.
  always_comb begin
    sq_has_credit = 1'b0;
    for (int unsigned v = 0; v < N_REGIONS; v++) begin
      if (sq_vfid == N_REGIONS_BITS'(v))
        sq_has_credit = (cnt[v] < CNT_W'(N_OUTSTANDING));
    end
  end

  assign s_sq.ready  = !nreset && (!sq_valid_q || m_sq.ready) && sq_has_credit;
  assign s_ack.ready = !nreset && (!ack_valid_q || m_ack.ready);

  assign sq_accept  = s_sq.valid && s_sq.ready;
  assign ack_accept = s_ack.valid && s_ack.ready;
  assign ack_pos    = ack_accept && !s_ack.data.is_nak;

  always_ff @(posedge nclk) begin
    if (nreset) begin
      sq_valid_q <= 1'b0;
      sq_data_q  <= '0;
    end else if (sq_accept) begin
      sq_valid_q <= 1'b1;
      sq_data_q  <= s_sq.data;
    end else if (m_sq.ready) begin
      sq_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge nclk) begin
    if (nreset) begin
      ack_valid_q <= 1'b0;
      ack_data_q  <= '0;
    end else if (ack_accept) begin
      ack_valid_q <= 1'b1;
      ack_data_q  <= s_ack.data;
    end else if (m_ack.ready) begin
      ack_valid_q <= 1'b0;
    end
  end

  for (genvar v = 0; v < N_REGIONS; v++) begin : g_cnt
    assign inc[v] = sq_accept && (sq_vfid == N_REGIONS_BITS'(v));
    assign dec[v] = ack_pos && (ack_vfid == N_REGIONS_BITS'(v));

    rdma_credit_cnt #(
      .MAX   (N_OUTSTANDING),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (nclk),
      .rst       (nreset),
      .inc       (inc[v]),
      .dec       (dec[v]),
      .cnt       (cnt[v]),
      .full      (full[v]),
      .underflow (underflow[v])
    );
  end

  always_ff @(posedge nclk) begin
    if (nreset) begin
      nak_cnt_q    <= '0;
      credit_err_q <= 1'b0;
    end else begin
      if (ack_accept && s_ack.data.is_nak) nak_cnt_q <= nak_cnt_q + 32'd1;
      if (|underflow) credit_err_q <= 1'b1;
    end
  end

  assign m_sq.valid   = sq_valid_q;
  assign m_sq.data    = sq_data_q;
  assign m_ack.valid  = ack_valid_q;
  assign m_ack.data   = ack_data_q;
  assign credit_stall = full;
  assign nak_count    = nak_cnt_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_rdma_sq_credit_ctrl.sv
// Self-checking bench for rdma_sq_credit_ctrl: directed credit scenarios plus a
// randomized backpressure run, all checked against a queue/array reference model.
module tb_rdma_sq_credit_ctrl;
  import rdma_sq_credit_ctrl_pkg::*;

  localparam int unsigned NOUT = 4;
  localparam int unsigned NREG = DEF_N_REGIONS;
  localparam int unsigned CW   = $clog2(NOUT + 1);

  logic            nclk = 1'b0;
  logic            nreset;
  logic [NREG-1:0] credit_stall;
  logic [31:0]     nak_count;
  logic            credit_err;

  always #5 nclk = ~nclk;

  rdma_req_if s_sq ();
  rdma_req_if m_sq ();
  rdma_ack_if s_ack ();
  rdma_ack_if m_ack ();

  rdma_sq_credit_ctrl #(
    .N_OUTSTANDING (NOUT),
    .N_REGIONS     (NREG)
  ) dut (
    .nclk         (nclk),
    .nreset       (nreset),
    .s_sq         (s_sq),
    .m_sq         (m_sq),
    .s_ack        (s_ack),
    .m_ack        (m_ack),
    .credit_stall (credit_stall),
    .nak_count    (nak_count),
    .credit_err   (credit_err)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model state
  int          mcnt [NREG];
  req_t        sq_q [$];
  ack_t        ack_q [$];
  int unsigned m_nak = 0;
  logic        m_err = 1'b0;

  // Handshakes seen on the DUT pins during the last step
  logic        obs_sq_hs;
  logic        obs_out_hs;
  int unsigned max_cnt_seen = 0;

  function automatic int vf(input req_t r);
    logic [N_REGIONS_BITS-1:0] b;
    b = r.qpn[PID_BITS +: N_REGIONS_BITS];
    return int'(b);
  endfunction

  function automatic req_t mk_req(input int v);
    req_t r;
    r.opcode = 5'($urandom);
    r.qpn    = 24'($urandom);
    r.qpn[PID_BITS +: N_REGIONS_BITS] = N_REGIONS_BITS'(v);
    r.host   = 1'($urandom);
    r.mode   = 1'($urandom);
    r.msg    = {$urandom, $urandom};
    return r;
  endfunction

  function automatic ack_t mk_ack(input logic nak, input int v);
    ack_t a;
    a.is_nak   = nak;
    a.pid      = PID_BITS'($urandom);
    a.vfid     = N_REGIONS_BITS'(v);
    a.syndrome = 8'($urandom);
    a.msn      = MSN_BITS'($urandom);
    return a;
  endfunction

  task automatic idle();
    s_sq.valid  = 1'b0;
    s_sq.data   = '0;
    s_ack.valid = 1'b0;
    s_ack.data  = '0;
    m_sq.ready  = 1'b1;
    m_ack.ready = 1'b1;
  endtask

  // One clock: compare every output against the model, advance the model, clock.
  task automatic step();
    logic            exp_sq_rdy, exp_ack_rdy, acc, ack_hs;
    logic [NREG-1:0] exp_stall;
    int              sv, av;
    #1;
    n_total++;
    if (m_sq.valid !== (sq_q.size() != 0))
      $display("FAIL m_sq_valid got=%0b want=%0b t=%0t", m_sq.valid, sq_q.size() != 0, $time);
    else n_pass++;
    if (sq_q.size() != 0) begin
      n_total++;
      if (m_sq.data !== sq_q[0]) $display("FAIL m_sq_data got=%h want=%h t=%0t", m_sq.data, sq_q[0], $time);
      else n_pass++;
    end
    n_total++;
    if (m_ack.valid !== (ack_q.size() != 0))
      $display("FAIL m_ack_valid got=%0b want=%0b t=%0t", m_ack.valid, ack_q.size() != 0, $time);
    else n_pass++;
    if (ack_q.size() != 0) begin
      n_total++;
      if (m_ack.data !== ack_q[0]) $display("FAIL m_ack_data got=%h want=%h t=%0t", m_ack.data, ack_q[0], $time);
      else n_pass++;
    end
    for (int v = 0; v < int'(NREG); v++) exp_stall[v] = (mcnt[v] == int'(NOUT));
    n_total++;
    if (credit_stall !== exp_stall) $display("FAIL credit_stall got=%b want=%b t=%0t", credit_stall, exp_stall, $time);
    else n_pass++;
    n_total++;
    if (nak_count !== m_nak) $display("FAIL nak_count got=%0d want=%0d t=%0t", nak_count, m_nak, $time);
    else n_pass++;
    n_total++;
    if (credit_err !== m_err) $display("FAIL credit_err got=%0b want=%0b t=%0t", credit_err, m_err, $time);
    else n_pass++;
    for (int v = 0; v < int'(NREG); v++) begin
      n_total++;
      if (dut.cnt[v] !== CW'(mcnt[v])) $display("FAIL cnt[%0d] got=%0d want=%0d t=%0t", v, dut.cnt[v], mcnt[v], $time);
      else n_pass++;
      if (int'(dut.cnt[v]) > int'(max_cnt_seen)) max_cnt_seen = dut.cnt[v];
    end

    sv = vf(s_sq.data);
    av = int'(s_ack.data.vfid);
    exp_sq_rdy  = !nreset && (sq_q.size() == 0 || m_sq.ready) && (mcnt[sv] < int'(NOUT));
    exp_ack_rdy = !nreset && (ack_q.size() == 0 || m_ack.ready);
    n_total++;
    if (s_sq.ready !== exp_sq_rdy) $display("FAIL s_sq_ready got=%0b want=%0b t=%0t", s_sq.ready, exp_sq_rdy, $time);
    else n_pass++;
    n_total++;
    if (s_ack.ready !== exp_ack_rdy) $display("FAIL s_ack_ready got=%0b want=%0b t=%0t", s_ack.ready, exp_ack_rdy, $time);
    else n_pass++;

    obs_sq_hs  = s_sq.valid && s_sq.ready;
    obs_out_hs = m_sq.valid && m_sq.ready;
    acc    = s_sq.valid && exp_sq_rdy;
    ack_hs = s_ack.valid && exp_ack_rdy;

    if (nreset) begin
      sq_q.delete();
      ack_q.delete();
      for (int v = 0; v < int'(NREG); v++) mcnt[v] = 0;
      m_nak = 0;
      m_err = 1'b0;
    end else begin
      if (sq_q.size() != 0 && m_sq.ready) void'(sq_q.pop_front());
      if (acc) begin
        sq_q.push_back(s_sq.data);
        mcnt[sv]++;
      end
      if (ack_q.size() != 0 && m_ack.ready) void'(ack_q.pop_front());
      if (ack_hs) begin
        ack_q.push_back(s_ack.data);
        if (s_ack.data.is_nak) m_nak++;
        else if (mcnt[av] == 0) m_err = 1'b1;
        else mcnt[av]--;
      end
    end
    @(posedge nclk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    idle();
    step();
    step();
    n_total++;
    if (s_sq.ready !== 1'b0) $display("FAIL reset_s_sq_ready got=%0b want=0", s_sq.ready);
    else n_pass++;
    n_total++;
    if (m_sq.valid !== 1'b0 || m_ack.valid !== 1'b0)
      $display("FAIL reset_valids got=%0b%0b want=00", m_sq.valid, m_ack.valid);
    else n_pass++;
    nreset = 1'b0;
    step();
  endtask

  task automatic test_credit_fill();
    int got = 0;
    s_sq.valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      s_sq.data = mk_req(1);
      step();
      if (obs_sq_hs) got++;
    end
    n_total++;
    if (got != 4) $display("FAIL fill_accepted got=%0d want=4", got);
    else n_pass++;
    n_total++;
    if (credit_stall !== 4'b0010) $display("FAIL fill_stall got=%b want=0010", credit_stall);
    else n_pass++;
    n_total++;
    if (s_sq.ready !== 1'b0) $display("FAIL fill_ready got=%0b want=0", s_sq.ready);
    else n_pass++;

    got = 0;
    s_ack.valid = 1'b1;
    s_ack.data  = mk_ack(1'b0, 1);
    step();
    if (obs_sq_hs) got++;
    s_ack.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_sq.data = mk_req(1);
      step();
      if (obs_sq_hs) got++;
    end
    s_sq.valid = 1'b0;
    n_total++;
    if (got != 1) $display("FAIL ack_reopen_accepted got=%0d want=1", got);
    else n_pass++;
    n_total++;
    if (dut.cnt[1] !== CW'(4)) $display("FAIL ack_reopen_cnt1 got=%0d want=4", dut.cnt[1]);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    ack_t a;
    s_ack.valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_ack.data = mk_ack(1'b0, 1);
      step();
    end
    s_ack.valid = 1'b0;
    step();
    n_total++;
    if (dut.cnt[1] !== CW'(2)) $display("FAIL same_pre_cnt1 got=%0d want=2", dut.cnt[1]);
    else n_pass++;

    a = mk_ack(1'b0, 1);
    s_sq.valid  = 1'b1;
    s_sq.data   = mk_req(1);
    s_ack.valid = 1'b1;
    s_ack.data  = a;
    step();
    s_sq.valid  = 1'b0;
    s_ack.valid = 1'b0;
    n_total++;
    if (dut.cnt[1] !== CW'(2)) $display("FAIL same_region_cnt1 got=%0d want=2", dut.cnt[1]);
    else n_pass++;
    n_total++;
    if (m_ack.valid !== 1'b1 || m_ack.data !== a)
      $display("FAIL same_region_ack_fwd got=%0b/%h want=1/%h", m_ack.valid, m_ack.data, a);
    else n_pass++;
    step();

    s_sq.valid  = 1'b1;
    s_sq.data   = mk_req(0);
    s_ack.valid = 1'b1;
    s_ack.data  = mk_ack(1'b0, 1);
    step();
    s_sq.valid  = 1'b0;
    s_ack.valid = 1'b0;
    n_total++;
    if (dut.cnt[0] !== CW'(1)) $display("FAIL split_cnt0 got=%0d want=1", dut.cnt[0]);
    else n_pass++;
    n_total++;
    if (dut.cnt[1] !== CW'(1)) $display("FAIL split_cnt1 got=%0d want=1", dut.cnt[1]);
    else n_pass++;
    step();
  endtask

  task automatic test_nak();
    s_ack.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_ack.data = mk_ack(1'b1, int'($urandom_range(0, NREG - 1)));
      step();
    end
    s_ack.valid = 1'b0;
    step();
    n_total++;
    if (nak_count !== 32'd3) $display("FAIL nak_count3 got=%0d want=3", nak_count);
    else n_pass++;
    n_total++;
    if (dut.cnt[0] !== CW'(1) || dut.cnt[1] !== CW'(1))
      $display("FAIL nak_cnts got=%0d,%0d want=1,1", dut.cnt[0], dut.cnt[1]);
    else n_pass++;
    n_total++;
    if (credit_err !== 1'b0) $display("FAIL err_before got=%0b want=0", credit_err);
    else n_pass++;

    s_ack.valid = 1'b1;
    s_ack.data  = mk_ack(1'b0, 2);
    step();
    s_ack.valid = 1'b0;
    n_total++;
    if (credit_err !== 1'b1) $display("FAIL err_underflow got=%0b want=1", credit_err);
    else n_pass++;
    n_total++;
    if (dut.cnt[2] !== CW'(0)) $display("FAIL err_cnt2 got=%0d want=0", dut.cnt[2]);
    else n_pass++;
    step();
    step();
  endtask

  task automatic test_random();
    int unsigned sent = 0, outs = 0, cyc = 0;
    logic        pend = 1'b0;
    req_t        cur  = '0;
    int          v;
    max_cnt_seen = 0;
    while ((sent < 1000 || sq_q.size() != 0) && cyc < 40000) begin
      if (!pend && sent < 1000 && $urandom_range(0, 4) != 0) begin
        cur  = mk_req(int'($urandom_range(0, NREG - 1)));
        pend = 1'b1;
      end
      s_sq.valid = pend;
      s_sq.data  = cur;
      m_sq.ready = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      v = int'($urandom_range(0, NREG - 1));
      s_ack.valid = ($urandom_range(0, 2) == 0) && (mcnt[v] > 0);
      s_ack.data  = mk_ack($urandom_range(0, 4) == 0, v);
      m_ack.ready = ($urandom_range(0, 3) != 0);
      step();
      if (obs_sq_hs) begin
        pend = 1'b0;
        sent++;
      end
      if (obs_out_hs) outs++;
      cyc++;
    end
    idle();
    step();
    step();
    n_total++;
    if (cyc >= 40000) $display("FAIL random_timeout sent=%0d want=1000", sent);
    else n_pass++;
    n_total++;
    if (outs != 1000) $display("FAIL random_out_count got=%0d want=1000", outs);
    else n_pass++;
    n_total++;
    if (max_cnt_seen > NOUT) $display("FAIL random_max_cnt got=%0d want<=%0d", max_cnt_seen, NOUT);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    nreset = 1'b1;
    step();
    nreset = 1'b0;
    s_sq.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_sq.data = mk_req(0);
      if (i == 2) begin
        s_ack.valid = 1'b1;
        s_ack.data  = mk_ack(1'b1, 3);
        m_ack.ready = 1'b0;
      end
      step();
    end
    s_sq.valid  = 1'b0;
    s_ack.valid = 1'b0;
    m_sq.ready  = 1'b0;
    step();
    n_total++;
    if (m_sq.valid !== 1'b1 || dut.cnt[0] !== CW'(3))
      $display("FAIL mid_setup got=%0b/%0d want=1/3", m_sq.valid, dut.cnt[0]);
    else n_pass++;

    nreset = 1'b1;
    step();
    n_total++;
    if (m_sq.valid !== 1'b0 || m_ack.valid !== 1'b0 || s_sq.ready !== 1'b0 || s_ack.ready !== 1'b0)
      $display("FAIL mid_valids_readies got=%0b%0b%0b%0b want=0000", m_sq.valid, m_ack.valid, s_sq.ready, s_ack.ready);
    else n_pass++;
    n_total++;
    if (credit_stall !== '0 || nak_count !== '0 || credit_err !== 1'b0)
      $display("FAIL mid_status got=%b/%0d/%0b want=0/0/0", credit_stall, nak_count, credit_err);
    else n_pass++;
    n_total++;
    if (dut.cnt[0] !== '0) $display("FAIL mid_cnt0 got=%0d want=0", dut.cnt[0]);
    else n_pass++;

    nreset      = 1'b0;
    m_sq.ready  = 1'b1;
    m_ack.ready = 1'b1;
    s_sq.valid  = 1'b1;
    s_sq.data   = mk_req(0);
    step();
    n_total++;
    if (obs_sq_hs !== 1'b1) $display("FAIL mid_first_accept got=%0b want=1", obs_sq_hs);
    else n_pass++;
    s_sq.valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    for (int v = 0; v < int'(NREG); v++) mcnt[v] = 0;
    nreset = 1'b1;
    idle();
    @(posedge nclk);
    #1;
    test_reset();
    test_credit_fill();
    test_same_cycle();
    test_nak();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
